// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter with a valid/ready load port and a shift-enabled serial output.
// Define PISO_TX_PARITY_EN to append an even-parity bit to each frame.
module piso_tx #(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_data,
   input  logic             shift,
   output logic             serial_out,
   output logic             serial_valid,
   output logic             last,
   output logic             busy
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef PISO_TX_PARITY_EN
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_PARITY = 2'd2} state_t;
`else
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1} state_t;
`endif

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   shreg_q, shreg_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               head_bit;
`ifdef PISO_TX_PARITY_EN
   logic               par_q, par_d;
`endif

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
`ifdef PISO_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
`ifdef PISO_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   // Bit at the output end of the shift register
   always_comb begin
      head_bit = 1'b0;
      if (MSB_FIRST) head_bit = shreg_q[WIDTH-1];
      else           head_bit = shreg_q[0];
   end

   // Next-state logic and output decode
   always_comb begin
      state_d      = state_q;
      shreg_d      = shreg_q;
      cnt_d        = cnt_q;
`ifdef PISO_TX_PARITY_EN
      par_d        = par_q;
`endif
      load_ready   = 1'b0;
      serial_out   = 1'b0;
      serial_valid = 1'b0;
      last         = 1'b0;

      case (state_q)
         S_IDLE: begin
            load_ready = ~reset;
            if (load_valid) begin
               shreg_d = load_data;
               cnt_d   = CNT_W'(WIDTH - 1);
`ifdef PISO_TX_PARITY_EN
               par_d   = ^load_data;
`endif
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            serial_valid = 1'b1;
            serial_out   = head_bit;
`ifndef PISO_TX_PARITY_EN
            last         = (cnt_q == '0);
`endif
            if (shift) begin
               // Shift toward the output end, zero-filling the vacated bit
               if (MSB_FIRST) shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
               else           shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
               if (cnt_q == '0) begin
`ifdef PISO_TX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_IDLE;
`endif
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
         end
`ifdef PISO_TX_PARITY_EN
         S_PARITY: begin
            serial_valid = 1'b1;
            serial_out   = par_q;
            last         = 1'b1;
            if (shift) state_d = S_IDLE;
         end
`endif
         default: state_d = S_IDLE;
      endcase

      busy = serial_valid;
   end

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx: MSB-first and LSB-first instances share all inputs
// and are compared against a per-bit reference computed from the loaded word.
module tb_piso_tx;

   localparam int unsigned W = 8;
`ifdef PISO_TX_PARITY_EN
   localparam int FL = W + 1;
`else
   localparam int FL = W;
`endif

   logic         clk = 1'b0;
   logic         reset;
   logic         load_valid;
   logic [W-1:0] load_data;
   logic         shift;
   logic         m_ready, m_out, m_valid, m_last, m_busy;
   logic         l_ready, l_out, l_valid, l_last, l_busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(m_ready),
      .load_data(load_data), .shift(shift), .serial_out(m_out),
      .serial_valid(m_valid), .last(m_last), .busy(m_busy));

   piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(l_ready),
      .load_data(load_data), .shift(shift), .serial_out(l_out),
      .serial_valid(l_valid), .last(l_last), .busy(l_busy));

   // Reference: i-th transmitted bit of a frame carrying word w
   function automatic logic exp_bit(input logic [W-1:0] w, input bit msb, input int i);
      if (i >= int'(W)) return ^w;
      return msb ? w[int'(W) - 1 - i] : w[i];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; load_valid = 1'b0; load_data = '0; shift = 1'b0;
      step();
      total++;
      if (m_ready !== 1'b0 || l_ready !== 1'b0 || m_valid !== 1'b0 || m_out !== 1'b0 ||
          m_last !== 1'b0 || m_busy !== 1'b0 || l_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_hold: ready=%b valid=%b out=%b last=%b busy=%b want 0 0 0 0 0",
                  m_ready, m_valid, m_out, m_last, m_busy);
      end
      reset = 1'b0;
      #1;
      total++;
      if (m_ready !== 1'b1 || l_ready !== 1'b1 || m_valid !== 1'b0 || m_busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_release: ready=%b valid=%b busy=%b want 1 0 0", m_ready, m_valid, m_busy);
      end
      step();
   endtask

   task automatic test_msb_word();
      logic [W-1:0] w = 8'hA5;
      load_data = w; load_valid = 1'b1; shift = 1'b1;
      step();
      load_valid = 1'b0;
      for (int i = 0; i < FL; i++) begin
         total++;
         if (m_out !== exp_bit(w, 1'b1, i) || m_valid !== 1'b1 || m_busy !== 1'b1 ||
             m_last !== (i == FL - 1) || m_ready !== 1'b0) begin
            bad++;
            $display("FAIL msb_bit%0d: out=%b want %b valid=%b last=%b want %b ready=%b",
                     i, m_out, exp_bit(w, 1'b1, i), m_valid, m_last, (i == FL - 1), m_ready);
         end
         step();
      end
      total++;
      if (m_ready !== 1'b1 || m_valid !== 1'b0 || m_last !== 1'b0) begin
         bad++;
         $display("FAIL msb_end: ready=%b valid=%b last=%b want 1 0 0", m_ready, m_valid, m_last);
      end
   endtask

   task automatic test_lsb_word();
      logic [W-1:0] w = 8'h01;
      load_data = w; load_valid = 1'b1; shift = 1'b1;
      step();
      load_valid = 1'b0;
      for (int i = 0; i < FL; i++) begin
         total++;
         if (l_out !== exp_bit(w, 1'b0, i) || l_valid !== 1'b1 || l_last !== (i == FL - 1)) begin
            bad++;
            $display("FAIL lsb_bit%0d: out=%b want %b valid=%b last=%b", i, l_out,
                     exp_bit(w, 1'b0, i), l_valid, l_last);
         end
         step();
      end
      total++;
      if (l_ready !== 1'b1 || l_valid !== 1'b0) begin
         bad++;
         $display("FAIL lsb_end: ready=%b valid=%b want 1 0", l_ready, l_valid);
      end
   endtask

   task automatic test_stall();
      logic [W-1:0] w = 8'h6B;
      load_data = w; load_valid = 1'b1; shift = 1'b1;
      step();
      load_valid = 1'b0;
      for (int i = 0; i < 3; i++) step();
      shift = 1'b0; load_valid = 1'b1; load_data = 8'hFF;
      for (int k = 0; k < 5; k++) begin
         step();
         total++;
         if (m_out !== exp_bit(w, 1'b1, 3) || l_out !== exp_bit(w, 1'b0, 3) ||
             m_last !== 1'b0 || m_ready !== 1'b0 || m_valid !== 1'b1) begin
            bad++;
            $display("FAIL stall%0d: out=%b want %b last=%b ready=%b valid=%b", k, m_out,
                     exp_bit(w, 1'b1, 3), m_last, m_ready, m_valid);
         end
      end
      load_valid = 1'b0; shift = 1'b1;
      for (int i = 3; i < FL; i++) begin
         total++;
         if (m_out !== exp_bit(w, 1'b1, i) || l_out !== exp_bit(w, 1'b0, i) ||
             m_last !== (i == FL - 1)) begin
            bad++;
            $display("FAIL stall_resume%0d: msb=%b want %b lsb=%b want %b last=%b", i, m_out,
                     exp_bit(w, 1'b1, i), l_out, exp_bit(w, 1'b0, i), m_last);
         end
         step();
      end
      step();
      total++;
      if (m_valid !== 1'b0 || m_ready !== 1'b1) begin
         bad++;
         $display("FAIL stall_no_reload: valid=%b ready=%b want 0 1", m_valid, m_ready);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] w0 = 8'h3C;
      logic [W-1:0] w1 = 8'hC3;
      load_data = w0; load_valid = 1'b1; shift = 1'b1;
      step();
      load_data = w1;
      for (int i = 0; i < FL; i++) begin
         total++;
         if (m_out !== exp_bit(w0, 1'b1, i) || m_valid !== 1'b1) begin
            bad++;
            $display("FAIL b2b_f0_bit%0d: out=%b want %b valid=%b", i, m_out, exp_bit(w0, 1'b1, i), m_valid);
         end
         step();
      end
      total++;
      if (m_valid !== 1'b0 || m_ready !== 1'b1) begin
         bad++;
         $display("FAIL b2b_gap: valid=%b ready=%b want 0 1", m_valid, m_ready);
      end
      step();
      load_valid = 1'b0;
      for (int i = 0; i < FL; i++) begin
         total++;
         if (m_out !== exp_bit(w1, 1'b1, i) || l_out !== exp_bit(w1, 1'b0, i) || m_valid !== 1'b1) begin
            bad++;
            $display("FAIL b2b_f1_bit%0d: msb=%b want %b lsb=%b want %b", i, m_out,
                     exp_bit(w1, 1'b1, i), l_out, exp_bit(w1, 1'b0, i));
         end
         step();
      end
      for (int k = 0; k < 6; k++) begin
         shift = ~shift;
         step();
         total++;
         if (m_valid !== 1'b0 || m_out !== 1'b0 || m_ready !== 1'b1 || m_last !== 1'b0) begin
            bad++;
            $display("FAIL idle_shift%0d: valid=%b out=%b ready=%b last=%b want 0 0 1 0",
                     k, m_valid, m_out, m_ready, m_last);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] w = 8'h0F;
      load_data = 8'h96; load_valid = 1'b1; shift = 1'b1;
      step();
      load_valid = 1'b0;
      for (int i = 0; i < 4; i++) step();
      reset = 1'b1;
      #1;
      total++;
      if (m_valid !== 1'b0 || m_out !== 1'b0 || m_ready !== 1'b0 || m_busy !== 1'b0 || l_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid: valid=%b out=%b ready=%b busy=%b want 0 0 0 0",
                  m_valid, m_out, m_ready, m_busy);
      end
      step();
      step();
      reset = 1'b0;
      #1;
      total++;
      if (m_ready !== 1'b1 || m_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid_release: ready=%b valid=%b want 1 0", m_ready, m_valid);
      end
      load_data = w; load_valid = 1'b1;
      step();
      load_valid = 1'b0;
      for (int i = 0; i < FL; i++) begin
         total++;
         if (m_out !== exp_bit(w, 1'b1, i) || l_out !== exp_bit(w, 1'b0, i) ||
             m_last !== (i == FL - 1)) begin
            bad++;
            $display("FAIL post_reset_bit%0d: msb=%b want %b lsb=%b want %b last=%b", i, m_out,
                     exp_bit(w, 1'b1, i), l_out, exp_bit(w, 1'b0, i), m_last);
         end
         step();
      end
   endtask

   task automatic test_random();
      for (int f = 0; f < 24; f++) begin
         logic [W-1:0] w;
         int idx;
         int cyc;
         bit s;
         w = W'($urandom);
         load_data = w; load_valid = 1'b1; shift = 1'(($urandom_range(0, 1)));
         step();
         load_valid = 1'b0; load_data = W'($urandom);
         idx = 0; cyc = 0;
         while (idx < FL && cyc < 400) begin
            s = ($urandom_range(0, 3) != 0);
            shift = s;
            total++;
            if (m_valid !== 1'b1 || m_out !== exp_bit(w, 1'b1, idx) || l_out !== exp_bit(w, 1'b0, idx) ||
                m_last !== (idx == FL - 1) || l_last !== (idx == FL - 1) || m_ready !== 1'b0) begin
               bad++;
               $display("FAIL rand_f%0d_bit%0d: word=%h msb=%b want %b lsb=%b want %b last=%b valid=%b",
                        f, idx, w, m_out, exp_bit(w, 1'b1, idx), l_out, exp_bit(w, 1'b0, idx), m_last, m_valid);
            end
            step();
            if (s) idx++;
            cyc++;
         end
         total++;
         if (idx != FL) begin
            bad++;
            $display("FAIL rand_f%0d_timeout: bits=%0d want %0d", f, idx, FL);
         end
         total++;
         if (m_valid !== 1'b0 || m_ready !== 1'b1 || l_valid !== 1'b0) begin
            bad++;
            $display("FAIL rand_f%0d_end: valid=%b ready=%b want 0 1", f, m_valid, m_ready);
         end
         if ($urandom_range(0, 1) != 0) step();
      end
   endtask

`ifdef PISO_TX_PARITY_EN
   task automatic test_parity();
      logic [W-1:0] words [2] = '{8'h07, 8'h03};
      logic         pars  [2] = '{1'b1, 1'b0};
      for (int t = 0; t < 2; t++) begin
         load_data = words[t]; load_valid = 1'b1; shift = 1'b1;
         step();
         load_valid = 1'b0;
         for (int i = 0; i < int'(W); i++) step();
         total++;
         if (m_out !== pars[t] || l_out !== pars[t] || m_last !== 1'b1 || m_valid !== 1'b1) begin
            bad++;
            $display("FAIL parity_%h: out=%b want %b last=%b valid=%b", words[t], m_out, pars[t], m_last, m_valid);
         end
         step();
         total++;
         if (m_valid !== 1'b0 || m_ready !== 1'b1) begin
            bad++;
            $display("FAIL parity_%h_end: valid=%b ready=%b want 0 1", words[t], m_valid, m_ready);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_msb_word();
      test_lsb_word();
      test_stall();
      test_back_to_back();
      test_reset_mid();
      test_random();
`ifdef PISO_TX_PARITY_EN
      test_parity();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
